// File: rtl/ftdi_fifo_controller_pkg.sv
// Shared definitions for the FT245-style FIFO pin controller:
// data width, default timing constants, FSM state encoding and
// helpers used to size the shared phase timer.
package ftdi_fifo_controller_pkg;

  localparam int unsigned DATA_W = 8;

  // Default strobe timing, in in_clk cycles
  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_RD_LOW_CYC   = 4;
  localparam int unsigned DEF_WR_SETUP_CYC = 2;
  localparam int unsigned DEF_WR_LOW_CYC   = 4;
  localparam int unsigned DEF_WR_HOLD_CYC  = 1;
  localparam int unsigned DEF_RECOVER_CYC  = 4;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RD_LOW   = 4'd1,
    ST_RX_REQ   = 4'd2,
    ST_RX_REL   = 4'd3,
    ST_WR_SETUP = 4'd4,
    ST_WR_LOW   = 4'd5,
    ST_WR_HOLD  = 4'd6,
    ST_TX_ACK   = 4'd7,
    ST_RECOVER  = 4'd8
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Timer counts down from (cycles-1) to 0, so it needs to hold max-1.
  function automatic int unsigned timer_w(input int unsigned max_cyc);
    return (max_cyc > 1) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/ftdi_fifo_controller_sync.sv
// Flag synchroniser: STAGES-deep flop chain for an asynchronous,
// active-low FIFO flag. Resets to 1 so the flag reads inactive.
// Ports: clk, reset_n (async, active-low), async_in (raw pin),
//        sync_out (synchronised level).
module ftdi_fifo_controller_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= '1;
    else          chain <= {chain[STAGES-2:0], async_in};
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/ftdi_fifo_controller.sv
// Pin-level controller for an FT245-style asynchronous byte FIFO.
// Generates RD#/WR# strobes, owns the bidirectional data bus and turns
// each FIFO transfer into a 4-phase req/ack handshake with the application.
// Ports:
//   in_clk, in_reset_n             clock, async active-low reset
//   in_ftdi_rxf_n, in_ftdi_txe_n   raw FIFO flags (async, active-low)
//   io_ftdi_data                   FIFO data bus
//   out_ftdi_rd_n, out_ftdi_wr_n   FIFO strobes (active-low, registered)
//   in_rx_en                       permission to start a new read
//   out_rx_data, out_rx_hsk_req,
//   in_rx_hsk_ack                  RX handshake (this block produces)
//   in_tx_hsk_req, in_tx_data,
//   out_tx_hsk_ack                 TX handshake (this block consumes)
module ftdi_fifo_controller
  import ftdi_fifo_controller_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned RD_LOW_CYC   = DEF_RD_LOW_CYC,
  parameter int unsigned WR_SETUP_CYC = DEF_WR_SETUP_CYC,
  parameter int unsigned WR_LOW_CYC   = DEF_WR_LOW_CYC,
  parameter int unsigned WR_HOLD_CYC  = DEF_WR_HOLD_CYC,
  parameter int unsigned RECOVER_CYC  = DEF_RECOVER_CYC
) (
  input  logic              in_clk,
  input  logic              in_reset_n,
  input  logic              in_ftdi_rxf_n,
  input  logic              in_ftdi_txe_n,
  inout  wire  [DATA_W-1:0] io_ftdi_data,
  output logic              out_ftdi_rd_n,
  output logic              out_ftdi_wr_n,
  input  logic              in_rx_en,
  output logic [DATA_W-1:0] out_rx_data,
  output logic              out_rx_hsk_req,
  input  logic              in_rx_hsk_ack,
  input  logic              in_tx_hsk_req,
  input  logic [DATA_W-1:0] in_tx_data,
  output logic              out_tx_hsk_ack
);

  localparam int unsigned MAX_CYC = max_u(max_u(RD_LOW_CYC, WR_SETUP_CYC),
                                          max_u(max_u(WR_LOW_CYC, WR_HOLD_CYC), RECOVER_CYC));
  localparam int unsigned TW = timer_w(MAX_CYC);

  localparam logic [TW-1:0] RD_LOAD    = TW'(RD_LOW_CYC - 1);
  localparam logic [TW-1:0] SETUP_LOAD = TW'(WR_SETUP_CYC - 1);
  localparam logic [TW-1:0] WLOW_LOAD  = TW'(WR_LOW_CYC - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(WR_HOLD_CYC - 1);
  localparam logic [TW-1:0] REC_LOAD   = TW'(RECOVER_CYC - 1);

  state_t            state, state_d;
  logic [TW-1:0]     timer, timer_d;
  logic              rxf_s, txe_s;
  logic              bus_oe, bus_oe_d;
  logic              rd_n_d, wr_n_d, rx_req_d, tx_ack_d;
  logic              capture, latch;
  logic [DATA_W-1:0] tx_hold;

  // Flag synchronisers; handshake inputs are already on in_clk
  ftdi_fifo_controller_sync #(.STAGES(SYNC_STAGES)) u_sync_rxf (
    .clk      (in_clk),
    .reset_n  (in_reset_n),
    .async_in (in_ftdi_rxf_n),
    .sync_out (rxf_s)
  );

  ftdi_fifo_controller_sync #(.STAGES(SYNC_STAGES)) u_sync_txe (
    .clk      (in_clk),
    .reset_n  (in_reset_n),
    .async_in (in_ftdi_txe_n),
    .sync_out (txe_s)
  );

  // Single tristate driver from the registered output enable
  assign io_ftdi_data = bus_oe ? tx_hold : 'z;

  // State, timer and registered pin/handshake outputs
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state          <= ST_IDLE;
      timer          <= '0;
      out_ftdi_rd_n  <= 1'b1;
      out_ftdi_wr_n  <= 1'b1;
      bus_oe         <= 1'b0;
      out_rx_data    <= '0;
      out_rx_hsk_req <= 1'b0;
      out_tx_hsk_ack <= 1'b0;
      tx_hold        <= '0;
    end else begin
      state          <= state_d;
      timer          <= timer_d;
      out_ftdi_rd_n  <= rd_n_d;
      out_ftdi_wr_n  <= wr_n_d;
      bus_oe         <= bus_oe_d;
      out_rx_hsk_req <= rx_req_d;
      out_tx_hsk_ack <= tx_ack_d;
      if (capture) out_rx_data <= io_ftdi_data;
      if (latch)   tx_hold     <= in_tx_data;
    end
  end

  // Next state, timer and output decode
  always_comb begin
    state_d = state;
    timer_d = timer;
    capture = 1'b0;
    latch   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Leave only once the previous RX ack has been released;
        // a raised TX req is simply a pending write.
        if (!in_rx_hsk_ack) begin
          if (!rxf_s && in_rx_en) begin
            state_d = ST_RD_LOW;
            timer_d = RD_LOAD;
          end else if (!txe_s && in_tx_hsk_req) begin
            state_d = ST_WR_SETUP;
            timer_d = SETUP_LOAD;
            latch   = 1'b1;
          end
        end
      end
      ST_RD_LOW: begin
        if (timer == '0) begin
          capture = 1'b1;
          state_d = ST_RX_REQ;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      ST_RX_REQ: if (in_rx_hsk_ack) state_d = ST_RX_REL;
      ST_RX_REL: begin
        if (!in_rx_hsk_ack) begin
          state_d = ST_RECOVER;
          timer_d = REC_LOAD;
        end
      end
      ST_WR_SETUP: begin
        if (timer == '0) begin
          state_d = ST_WR_LOW;
          timer_d = WLOW_LOAD;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      ST_WR_LOW: begin
        if (timer == '0) begin
          state_d = ST_WR_HOLD;
          timer_d = HOLD_LOAD;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      ST_WR_HOLD: begin
        if (timer == '0) state_d = ST_TX_ACK;
        else             timer_d = timer - TW'(1);
      end
      ST_TX_ACK: begin
        if (!in_tx_hsk_req) begin
          state_d = ST_RECOVER;
          timer_d = REC_LOAD;
        end
      end
      ST_RECOVER: begin
        if (timer == '0) state_d = ST_IDLE;
        else             timer_d = timer - TW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    rd_n_d   = (state_d != ST_RD_LOW);
    wr_n_d   = (state_d != ST_WR_LOW);
    bus_oe_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_LOW) || (state_d == ST_WR_HOLD);
    // Handshake outputs follow the current state so they rise one cycle
    // after entry and drop on the edge that sees the peer's response.
    rx_req_d = (state == ST_RX_REQ) && !in_rx_hsk_ack;
    tx_ack_d = (state == ST_TX_ACK) && in_tx_hsk_req;
  end

endmodule

// File: tb/tb_ftdi_fifo_controller.sv
// Directed testbench for ftdi_fifo_controller with a small FT245 RX FIFO model.
module tb_ftdi_fifo_controller;

  logic       clk;
  logic       reset_n;
  logic       txe_n;
  wire        rxf_n;
  wire  [7:0] ftdi_data;
  logic       rd_n, wr_n;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_req, rx_ack;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_ack;

  int n_checks = 0;
  int n_pass   = 0;

  // RX FIFO model: bytes queued by the bench, popped when RD# rises
  logic [7:0] rx_mem [0:15];
  logic [3:0] rx_rd = '0;
  logic [3:0] rx_wr = '0;
  logic       rd_prev = 1'b1;
  int         contention_cnt = 0;
  int         rd_falls = 0;

  assign rxf_n     = (rx_rd == rx_wr);
  assign ftdi_data = (rd_n == 1'b0) ? rx_mem[rx_rd] : 8'hzz;

  always @(posedge clk) begin
    rd_prev <= rd_n;
    if (rd_n && !rd_prev && (rx_rd != rx_wr)) rx_rd <= rx_rd + 4'd1;
  end

  always @(negedge clk) begin
    if (!rd_n && dut.bus_oe) contention_cnt <= contention_cnt + 1;
    if (!rd_n && rd_prev)    rd_falls <= rd_falls + 1;
  end

  ftdi_fifo_controller dut (
    .in_clk         (clk),
    .in_reset_n     (reset_n),
    .in_ftdi_rxf_n  (rxf_n),
    .in_ftdi_txe_n  (txe_n),
    .io_ftdi_data   (ftdi_data),
    .out_ftdi_rd_n  (rd_n),
    .out_ftdi_wr_n  (wr_n),
    .in_rx_en       (rx_en),
    .out_rx_data    (rx_data),
    .out_rx_hsk_req (rx_req),
    .in_rx_hsk_ack  (rx_ack),
    .in_tx_hsk_req  (tx_req),
    .in_tx_data     (tx_data),
    .out_tx_hsk_ack (tx_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr = rx_wr + 4'd1;
  endtask

  // Waits for an RX req (bounded), returns byte and wait in cycles (-1 on timeout), then closes the handshake
  task automatic rx_handshake(output logic [7:0] data, output int lat);
    lat  = -1;
    data = '0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (rx_req) begin
        lat  = i;
        data = rx_data;
        break;
      end
    end
    if (lat < 0) return;
    rx_ack = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!rx_req) break;
    end
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    n_checks++; if (rd_n !== 1'b1) $display("FAIL reset_rd_n got %b want 1", rd_n); else n_pass++;
    n_checks++; if (wr_n !== 1'b1) $display("FAIL reset_wr_n got %b want 1", wr_n); else n_pass++;
    n_checks++; if (dut.bus_oe !== 1'b0) $display("FAIL reset_bus_oe got %b want 0", dut.bus_oe); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else n_pass++;
    n_checks++; if ({rx_req, tx_ack} !== 2'b00) $display("FAIL reset_hsk got %b want 00", {rx_req, tx_ack}); else n_pass++;
    reset_n = 1'b1;
    idle(4);
  endtask

  task automatic test_rx();
    int rd_first, low_cnt, gap;
    logic [7:0] d;
    int lat;
    rd_first = -1; low_cnt = 0;
    push_rx(8'h5A);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!rd_n) begin
        low_cnt++;
        if (rd_first < 0) rd_first = i;
      end
      if (i == 7) begin
        n_checks++; if (rx_req !== 1'b0) $display("FAIL rx_req_early got %b want 0", rx_req); else n_pass++;
      end
    end
    n_checks++; if (rd_first !== 3) $display("FAIL rx_rd_latency got %0d want 3", rd_first); else n_pass++;
    n_checks++; if (low_cnt !== 4) $display("FAIL rx_rd_low_len got %0d want 4", low_cnt); else n_pass++;
    n_checks++; if ({rx_req, rx_data} !== {1'b1, 8'h5A}) $display("FAIL rx_req_data got %b/%h want 1/5a", rx_req, rx_data); else n_pass++;
    rx_ack = 1'b1;
    @(negedge clk);
    n_checks++; if (rx_req !== 1'b0) $display("FAIL rx_req_drop got %b want 0", rx_req); else n_pass++;
    rx_ack = 1'b0;
    push_rx(8'h77);
    gap = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (!rd_n) begin gap = i; break; end
    end
    n_checks++; if (gap !== 6) $display("FAIL rx_recover_gap got %0d want 6", gap); else n_pass++;
    rx_handshake(d, lat);
    n_checks++; if (d !== 8'h77) $display("FAIL rx_second_byte got %h want 77", d); else n_pass++;
    idle(10);
  endtask

  task automatic test_tx();
    logic       wr_s  [1:14];
    logic       oe_s  [1:14];
    logic       ack_s [1:14];
    logic [7:0] bus_s [1:14];
    int oe_first, wr_first, wr_cnt, ack_first;
    oe_first = -1; wr_first = -1; wr_cnt = 0; ack_first = -1;
    txe_n = 1'b0;
    idle(4);
    tx_data = 8'hA5;
    tx_req  = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      wr_s[i] = wr_n; oe_s[i] = dut.bus_oe; ack_s[i] = tx_ack; bus_s[i] = ftdi_data;
      if (oe_s[i] && oe_first < 0) oe_first = i;
      if (!wr_s[i]) begin wr_cnt++; if (wr_first < 0) wr_first = i; end
      if (ack_s[i] && ack_first < 0) begin ack_first = i; tx_req = 1'b0; end
      if (i == 1) tx_data = 8'h00;
    end
    n_checks++; if (oe_first !== 1) $display("FAIL tx_bus_drive_start got %0d want 1", oe_first); else n_pass++;
    n_checks++; if (wr_first !== 3) $display("FAIL tx_wr_latency got %0d want 3", wr_first); else n_pass++;
    n_checks++; if (wr_cnt !== 4) $display("FAIL tx_wr_low_len got %0d want 4", wr_cnt); else n_pass++;
    n_checks++; if (bus_s[3] !== 8'hA5) $display("FAIL tx_bus_data got %h want a5", bus_s[3]); else n_pass++;
    n_checks++; if ({wr_s[7], oe_s[7], bus_s[7]} !== {2'b11, 8'hA5}) $display("FAIL tx_hold got %b%b/%h want 11/a5", wr_s[7], oe_s[7], bus_s[7]); else n_pass++;
    n_checks++; if (oe_s[8] !== 1'b0) $display("FAIL tx_bus_release got %b want 0", oe_s[8]); else n_pass++;
    n_checks++; if (ack_first !== 9) $display("FAIL tx_ack_latency got %0d want 9", ack_first); else n_pass++;
    n_checks++; if (ack_s[10] !== 1'b0) $display("FAIL tx_ack_drop got %b want 0", ack_s[10]); else n_pass++;
    idle(8);
  endtask

  task automatic test_contention();
    int rd_first, wr_first, ack_first, c0;
    logic [7:0] got_rx, got_tx;
    rd_first = -1; wr_first = -1; ack_first = -1; got_rx = '0; got_tx = '0;
    txe_n = 1'b1;
    idle(5);
    tx_data = 8'h96;
    tx_req  = 1'b1;
    idle(3);
    c0 = contention_cnt;
    push_rx(8'hC3);
    txe_n = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (!rd_n && rd_first < 0) rd_first = i;
      if (!wr_n && wr_first < 0) begin wr_first = i; got_tx = ftdi_data; end
      if (rx_req && !rx_ack) begin got_rx = rx_data; rx_ack = 1'b1; end
      else if (!rx_req && rx_ack) rx_ack = 1'b0;
      if (tx_ack && ack_first < 0) begin ack_first = i; tx_req = 1'b0; end
      if (ack_first > 0 && !tx_ack) break;
    end
    n_checks++; if (rd_first !== 3) $display("FAIL cont_read_first got %0d want 3", rd_first); else n_pass++;
    n_checks++; if (got_rx !== 8'hC3) $display("FAIL cont_rx_data got %h want c3", got_rx); else n_pass++;
    n_checks++; if (wr_first !== 17) $display("FAIL cont_write_start got %0d want 17", wr_first); else n_pass++;
    n_checks++; if ({got_tx, ack_first} !== {8'h96, 32'd23}) $display("FAIL cont_tx got %h/%0d want 96/23", got_tx, ack_first); else n_pass++;
    n_checks++; if (contention_cnt - c0 !== 0) $display("FAIL cont_bus_during_read got %0d want 0", contention_cnt - c0); else n_pass++;
    idle(8);
  endtask

  task automatic test_flow();
    int wr_cnt, ack_cnt, wr_first, ack_first;
    logic [7:0] got;
    wr_cnt = 0; ack_cnt = 0; wr_first = -1; ack_first = -1; got = '0;
    txe_n = 1'b1;
    idle(5);
    tx_data = 8'h3C;
    tx_req  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!wr_n || dut.bus_oe) wr_cnt++;
      if (tx_ack) ack_cnt++;
    end
    n_checks++; if ({wr_cnt, ack_cnt} !== {32'd0, 32'd0}) $display("FAIL flow_stall got wr=%0d ack=%0d want 0/0", wr_cnt, ack_cnt); else n_pass++;
    txe_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!wr_n && wr_first < 0) begin wr_first = i; got = ftdi_data; end
      if (tx_ack && ack_first < 0) begin ack_first = i; tx_req = 1'b0; end
      if (ack_first > 0 && !tx_ack) break;
    end
    n_checks++; if (wr_first !== 5) $display("FAIL flow_wr_after_txe got %0d want 5", wr_first); else n_pass++;
    n_checks++; if (got !== 8'h3C) $display("FAIL flow_data got %h want 3c", got); else n_pass++;
    n_checks++; if (ack_first !== 11) $display("FAIL flow_ack got %0d want 11", ack_first); else n_pass++;
    idle(8);
  endtask

  task automatic test_req_drop();
    int wr_cnt, ack_cnt;
    logic [7:0] got;
    wr_cnt = 0; ack_cnt = 0; got = '0;
    tx_data = 8'h81;
    tx_req  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) tx_req = 1'b0;
      if (!wr_n) begin if (wr_cnt == 0) got = ftdi_data; wr_cnt++; end
      if (tx_ack) ack_cnt++;
    end
    n_checks++; if (wr_cnt !== 4) $display("FAIL drop_write_completes got %0d want 4", wr_cnt); else n_pass++;
    n_checks++; if (got !== 8'h81) $display("FAIL drop_data got %h want 81", got); else n_pass++;
    n_checks++; if (ack_cnt !== 0) $display("FAIL drop_no_ack got %0d want 0", ack_cnt); else n_pass++;
    idle(4);
  endtask

  task automatic test_rx_en();
    int r0, lat;
    logic [7:0] d;
    rx_en = 1'b0;
    r0 = rd_falls;
    push_rx(8'h4D);
    idle(20);
    n_checks++; if (rd_falls - r0 !== 0) $display("FAIL rxen_block got %0d reads want 0", rd_falls - r0); else n_pass++;
    rx_en = 1'b1;
    rx_handshake(d, lat);
    n_checks++; if (lat !== 6) $display("FAIL rxen_latency got %0d want 6", lat); else n_pass++;
    n_checks++; if (d !== 8'h4D) $display("FAIL rxen_data got %h want 4d", d); else n_pass++;
    idle(8);
  endtask

  task automatic test_back_to_back();
    int r0, lat;
    logic [7:0] d;
    r0 = rd_falls;
    for (int b = 1; b <= 5; b++) push_rx(8'(b));
    for (int b = 1; b <= 5; b++) begin
      rx_handshake(d, lat);
      n_checks++; if (d !== 8'(b)) $display("FAIL burst_byte%0d got %h want %h", b, d, 8'(b)); else n_pass++;
    end
    idle(20);
    n_checks++; if (rd_falls - r0 !== 5) $display("FAIL burst_read_count got %0d want 5", rd_falls - r0); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int found;
    found = 0;
    tx_data = 8'hE7;
    tx_req  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!wr_n) begin found = 1; break; end
    end
    n_checks++; if (found !== 1) $display("FAIL rstw_reach_write got %0d want 1", found); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({wr_n, rd_n} !== 2'b11) $display("FAIL rstw_strobes got %b want 11", {wr_n, rd_n}); else n_pass++;
    n_checks++; if (dut.bus_oe !== 1'b0) $display("FAIL rstw_bus_oe got %b want 0", dut.bus_oe); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL rstw_rx_data got %h want 00", rx_data); else n_pass++;
    n_checks++; if ({rx_req, tx_ack} !== 2'b00) $display("FAIL rstw_hsk got %b want 00", {rx_req, tx_ack}); else n_pass++;
    tx_req = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(2);
  endtask

  initial begin
    reset_n = 1'b0;
    txe_n   = 1'b1;
    rx_en   = 1'b1;
    rx_ack  = 1'b0;
    tx_req  = 1'b0;
    tx_data = 8'h00;
    for (int i = 0; i < 16; i++) rx_mem[i] = 8'h00;
    test_reset();
    test_rx();
    test_tx();
    test_contention();
    test_flow();
    test_req_drop();
    test_rx_en();
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
